apb_split_n: RTL and testbench

- Parametrised 1-to-NSLV APB splitter for the core-local peripheral bus (config regs, status regs, interrupt controller, future slaves).
- Successor to the fixed three-way bit-decoded connector.
- Adds a base/mask address map with lowest-index priority and an internal default slave that returns PSLVERR for unmapped addresses.
- Adds a per-transfer access-phase timeout watchdog that aborts hung slaves and reports the event.

---
 rtl/apb_split_n.sv | 216 +++++++++++++++++++++
 tb/tb_apb_split_n.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_split_n.sv
// rtl/apb_split_n.sv - parametrised 1-to-NSLV APB splitter with address map, default slave and access watchdog
//
// Ports:
//   clk, rstn                 bus clock, asynchronous active-low reset
//   m_psel/m_penable/m_pwrite upstream APB controls
//   m_paddr/m_pstrb/m_pprot/m_pwdata  upstream request fields
//   m_prdata/m_pready/m_pslverr       response to the upstream master
//   s_psel/s_penable          per-slave select / enable (NSLV bits each)
//   s_paddr/s_pwrite/s_pstrb/s_pprot/s_pwdata  broadcast request fields
//   s_prdata/s_pready/s_pslverr       per-slave responses, slave i at [i*DW +: DW] / [i]
//   to_evt                    one-cycle pulse when a hung transfer is aborted
//   to_cnt                    saturating count of aborts
module apb_split_n #(
    parameter int                   NSLV     = 3,
    parameter int                   AW       = 32,
    parameter int                   DW       = 32,
    parameter logic [NSLV*AW-1:0]   SLV_BASE = {32'h0000_0000, 32'h0000_1000, 32'h0800_0000},
    parameter logic [NSLV*AW-1:0]   SLV_MASK = {32'h0800_1000, 32'h0800_1000, 32'h0800_0000},
    parameter int                   TIMEOUT  = 256
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 m_psel,
    input  logic                 m_penable,
    input  logic                 m_pwrite,
    input  logic [AW-1:0]        m_paddr,
    input  logic [DW/8-1:0]      m_pstrb,
    input  logic [2:0]           m_pprot,
    input  logic [DW-1:0]        m_pwdata,
    output logic [DW-1:0]        m_prdata,
    output logic                 m_pready,
    output logic                 m_pslverr,
    output logic [NSLV-1:0]      s_psel,
    output logic [NSLV-1:0]      s_penable,
    output logic [AW-1:0]        s_paddr,
    output logic                 s_pwrite,
    output logic [DW/8-1:0]      s_pstrb,
    output logic [2:0]           s_pprot,
    output logic [DW-1:0]        s_pwdata,
    input  logic [NSLV*DW-1:0]   s_prdata,
    input  logic [NSLV-1:0]      s_pready,
    input  logic [NSLV-1:0]      s_pslverr,
    output logic                 to_evt,
    output logic [7:0]           to_cnt
);

    // Selector encoding: 0..NSLV-1 are real slaves, NSLV is the default slave.
    localparam int             SW        = $clog2(NSLV + 1);
    localparam logic [SW-1:0]  DEF       = SW'(NSLV);
    localparam int             WDW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int             TO_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [WDW-1:0] TO_LAST   = WDW'(TO_LAST_I);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DEFERR = 2'd2,
        ABORT  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   sel_q, sel_d;
    logic [WDW-1:0]  wd_q, wd_d;
    logic [7:0]      to_cnt_q, to_cnt_d;

    logic            setup;
    logic            act;
    logic [NSLV-1:0] hit_vec;
    logic [NSLV-1:0] hit_oh;
    logic            hit_any;
    logic [SW-1:0]   hit_idx;
    logic [NSLV-1:0] sel_oh;
    logic            sel_rdy;
    logic            sel_err;
    logic [DW-1:0]   sel_rdata;

    assign setup = m_psel & ~m_penable;
    assign act   = m_psel &  m_penable;

    // Address decode. Iterating downwards leaves the lowest hitting index in hit_idx.
    always_comb begin
        hit_vec = '0;
        hit_idx = DEF;
        for (int i = NSLV - 1; i >= 0; i--) begin
            if ((m_paddr & SLV_MASK[i*AW +: AW]) == (SLV_BASE[i*AW +: AW] & SLV_MASK[i*AW +: AW])) begin
                hit_vec[i] = 1'b1;
                hit_idx    = SW'(i);
            end
        end
    end

    // Isolate the lowest set bit so overlapping windows select only one slave.
    assign hit_oh  = hit_vec & (~hit_vec + NSLV'(1));
    assign hit_any = |hit_vec;

    // Response mux from the slave latched during the setup cycle.
    always_comb begin
        sel_oh    = '0;
        sel_rdy   = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (sel_q == SW'(i)) begin
                sel_oh[i] = 1'b1;
                sel_rdy   = s_pready[i];
                sel_err   = s_pslverr[i];
                sel_rdata = s_prdata[i*DW +: DW];
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            sel_q    <= DEF;
            wd_q     <= '0;
            to_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            wd_q     <= wd_d;
            to_cnt_q <= to_cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        wd_d     = wd_q;
        to_cnt_d = to_cnt_q;
        case (state_q)
            IDLE: begin
                if (setup) begin
                    sel_d   = hit_idx;
                    wd_d    = '0;
                    state_d = hit_any ? ACCESS : DEFERR;
                end
            end
            ACCESS: begin
                if (!m_psel) begin
                    // Master abandoned the transfer: quietly return.
                    state_d = IDLE;
                end else if (act && sel_rdy) begin
                    state_d = IDLE;
                end else if (!sel_rdy) begin
                    if ((TIMEOUT != 0) && (wd_q == TO_LAST)) begin
                        state_d = ABORT;
                    end else begin
                        wd_d = wd_q + WDW'(1);
                    end
                end
            end
            DEFERR: begin
                state_d = IDLE;
            end
            ABORT: begin
                state_d = IDLE;
                if (to_cnt_q != 8'hFF) begin
                    to_cnt_d = to_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        s_psel    = '0;
        s_penable = '0;
        m_prdata  = '0;
        m_pready  = 1'b0;
        m_pslverr = 1'b0;
        to_evt    = 1'b0;
        case (state_q)
            IDLE: begin
                if (setup) begin
                    s_psel = hit_oh;
                end
            end
            ACCESS: begin
                s_psel    = sel_oh & {NSLV{m_psel}};
                s_penable = sel_oh & {NSLV{m_penable}};
                m_prdata  = sel_rdata;
                m_pready  = act & sel_rdy;
                m_pslverr = act & sel_err;
            end
            DEFERR: begin
                m_pready  = m_psel;
                m_pslverr = m_psel;
            end
            ABORT: begin
                m_pready  = m_psel;
                m_pslverr = m_psel;
                to_evt    = 1'b1;
            end
            default: begin
                s_psel = '0;
            end
        endcase
        // Selects must vanish the instant reset asserts, even while the master still drives a setup.
        s_psel    = s_psel    & {NSLV{rstn}};
        s_penable = s_penable & {NSLV{rstn}};
    end

    assign to_cnt   = to_cnt_q;
    assign s_paddr  = m_paddr;
    assign s_pwrite = m_pwrite;
    assign s_pstrb  = m_pstrb;
    assign s_pprot  = m_pprot;
    assign s_pwdata = m_pwdata;

endmodule

// File: tb/tb_apb_split_n.sv
// tb/tb_apb_split_n.sv - randomized self-checking bench for apb_split_n against a range-based reference model
module tb_apb_split_n;

    localparam int NS = 3;
    localparam int TO = 8;

    logic          clk;
    logic          rstn;
    logic          m_psel, m_penable, m_pwrite;
    logic [31:0]   m_paddr;
    logic [3:0]    m_pstrb;
    logic [2:0]    m_pprot;
    logic [31:0]   m_pwdata;
    logic [31:0]   m_prdata;
    logic          m_pready, m_pslverr;
    logic [NS-1:0] s_psel, s_penable;
    logic [31:0]   s_paddr;
    logic          s_pwrite;
    logic [3:0]    s_pstrb;
    logic [2:0]    s_pprot;
    logic [31:0]   s_pwdata;
    logic [NS*32-1:0] s_prdata;
    logic [NS-1:0] s_pready, s_pslverr;
    logic          to_evt;
    logic [7:0]    to_cnt;

    // Map: s0 = 0x0000_0000..0x0000_0FFF, s1 = 0x0000_0000..0x0000_1FFF (overlaps s0),
    // s2 = 0x0800_0000..0x0800_FFFF, everything else unmapped.
    apb_split_n #(
        .NSLV     (NS),
        .AW       (32),
        .DW       (32),
        .SLV_BASE ({32'h0800_0000, 32'h0000_0000, 32'h0000_0000}),
        .SLV_MASK ({32'hFFFF_0000, 32'hFFFF_E000, 32'hFFFF_F000}),
        .TIMEOUT  (TO)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .m_psel    (m_psel),
        .m_penable (m_penable),
        .m_pwrite  (m_pwrite),
        .m_paddr   (m_paddr),
        .m_pstrb   (m_pstrb),
        .m_pprot   (m_pprot),
        .m_pwdata  (m_pwdata),
        .m_prdata  (m_prdata),
        .m_pready  (m_pready),
        .m_pslverr (m_pslverr),
        .s_psel    (s_psel),
        .s_penable (s_penable),
        .s_paddr   (s_paddr),
        .s_pwrite  (s_pwrite),
        .s_pstrb   (s_pstrb),
        .s_pprot   (s_pprot),
        .s_pwdata  (s_pwdata),
        .s_prdata  (s_prdata),
        .s_pready  (s_pready),
        .s_pslverr (s_pslverr),
        .to_evt    (to_evt),
        .to_cnt    (to_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int model_to = 0;

    logic [31:0] rng_lo [NS] = '{32'h0000_0000, 32'h0000_0000, 32'h0800_0000};
    logic [31:0] rng_hi [NS] = '{32'h0000_0FFF, 32'h0000_1FFF, 32'h0800_FFFF};

    // Slave models: each becomes ready after lat[i] wait states; unselected slaves show junk ready.
    int          lat      [NS];
    logic [31:0] rdat     [NS];
    logic        err_v    [NS];
    logic [7:0]  acc_cnt  [NS];
    logic [NS-1:0] junk_rdy;

    always @(posedge clk) begin
        for (int i = 0; i < NS; i++) begin
            acc_cnt[i] <= (s_psel[i] && s_penable[i]) ? acc_cnt[i] + 8'd1 : 8'd0;
        end
    end

    always_comb begin
        s_pready  = '0;
        s_pslverr = '0;
        s_prdata  = '0;
        for (int i = 0; i < NS; i++) begin
            s_pready[i]         = (s_psel[i] && s_penable[i]) ? (int'(acc_cnt[i]) >= lat[i]) : junk_rdy[i];
            s_pslverr[i]        = err_v[i];
            s_prdata[i*32 +: 32] = rdat[i];
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int model_decode(input logic [31:0] a);
        for (int i = 0; i < NS; i++) begin
            if (a >= rng_lo[i] && a <= rng_hi[i]) return i;
        end
        return -1;
    endfunction

    // One complete transfer, checked cycle by cycle against the model.
    task automatic do_xfer(input logic [31:0] addr, input bit wr, input int lt,
                           input logic [31:0] rd, input bit er);
        int          e;
        int          done;
        bit          aborted;
        logic [2:0]  oh;
        logic [3:0]  strb;
        logic [2:0]  prot;
        logic [31:0] wd;
        e       = model_decode(addr);
        oh      = (e < 0) ? 3'b000 : 3'(1 << e);
        aborted = (e >= 0) && (lt + 1 > TO);
        done    = (e < 0) ? 1 : (aborted ? TO + 1 : lt + 1);
        strb    = 4'($urandom);
        prot    = 3'($urandom);
        wd      = $urandom;

        @(posedge clk); #1;
        for (int i = 0; i < NS; i++) begin
            lat[i]   = lt;
            rdat[i]  = $urandom;
            err_v[i] = 1'($urandom);
        end
        if (e >= 0) begin
            rdat[e]  = rd;
            err_v[e] = er;
        end
        junk_rdy  = 3'($urandom);
        m_psel    = 1'b1;
        m_penable = 1'b0;
        m_pwrite  = wr;
        m_paddr   = addr;
        m_pstrb   = strb;
        m_pprot   = prot;
        m_pwdata  = wd;

        @(negedge clk);
        check_eq("setup_psel",    s_psel, oh);
        check_eq("setup_penable", s_penable, 3'b000);
        check_eq("setup_pready",  m_pready, 1'b0);
        check_eq("setup_tocnt",   to_cnt, 8'(model_to));
        check_eq("bcast_addr",    s_paddr, addr);
        check_eq("bcast_ctl",     {s_pwrite, s_pstrb, s_pprot}, {wr, strb, prot});

        @(posedge clk); #1;
        m_penable = 1'b1;

        for (int c = 1; c <= done; c++) begin
            @(negedge clk);
            if (c < done) begin
                check_eq("wait_psel",    s_psel, oh);
                check_eq("wait_penable", s_penable, oh);
                check_eq("wait_pready",  m_pready, 1'b0);
                check_eq("wait_toevt",   to_evt, 1'b0);
                check_eq("wait_bcast",   {s_pstrb, s_pwdata}, {strb, wd});
            end else begin
                check_eq("end_psel",    s_psel, (e < 0 || aborted) ? 3'b000 : oh);
                check_eq("end_penable", s_penable, (e < 0 || aborted) ? 3'b000 : oh);
                check_eq("end_pready",  m_pready, 1'b1);
                check_eq("end_pslverr", m_pslverr, (e < 0 || aborted) ? 1'b1 : er);
                check_eq("end_prdata",  m_prdata, (e < 0 || aborted) ? 32'h0 : rd);
                check_eq("end_toevt",   to_evt, aborted);
            end
        end
        if (aborted && model_to < 255) model_to++;
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        m_psel    = 1'b0;
        m_penable = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        int          lt;
        int          lat_tab [7] = '{0, 1, 2, 3, 7, 8, 12};

        rstn      = 1'b0;
        m_psel    = 1'b0;
        m_penable = 1'b0;
        m_pwrite  = 1'b0;
        m_paddr   = '0;
        m_pstrb   = '0;
        m_pprot   = '0;
        m_pwdata  = '0;
        junk_rdy  = '0;
        for (int i = 0; i < NS; i++) begin
            lat[i]   = 0;
            rdat[i]  = '0;
            err_v[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_psel",   {s_psel, s_penable}, 6'b0);
        check_eq("rst_resp",   {m_pready, m_pslverr, m_prdata}, 34'h0);
        check_eq("rst_to",     {to_evt, to_cnt}, 9'h0);
        @(posedge clk); #1;
        rstn = 1'b1;

        // Directed cases
        do_xfer(32'h0000_1004, 1'b0, 0, 32'hA5A5_0001, 1'b0);
        do_xfer(32'h0800_0010, 1'b1, 3, 32'h1234_5678, 1'b0);
        do_xfer(32'h0000_0040, 1'b0, 1, 32'h0BAD_F00D, 1'b1);
        idle_cycle();
        do_xfer(32'h4000_0000, 1'b0, 0, 32'hDEAD_BEEF, 1'b0);
        do_xfer(32'h0800_0100, 1'b0, 20, 32'h5555_AAAA, 1'b0);
        do_xfer(32'h0000_1008, 1'b0, 0, 32'h0000_CAFE, 1'b0);
        do_xfer(32'h0800_0200, 1'b1, 7, 32'h7777_7777, 1'b0);

        // Randomized traffic, back-to-back or with an idle gap
        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 3))
                0: a = {20'h0, 12'($urandom)};
                1: a = {19'h0, 1'b1, 12'($urandom)};
                2: a = {16'h0800, 16'($urandom)};
                default: a = $urandom | 32'h4000_0000;
            endcase
            lt = lat_tab[$urandom_range(0, 6)];
            do_xfer(a, 1'($urandom), lt, $urandom, 1'($urandom));
            if ($urandom_range(0, 1) == 1) idle_cycle();
        end

        // Reset in the middle of an access phase
        @(posedge clk); #1;
        lat[2]    = 50;
        m_psel    = 1'b1;
        m_penable = 1'b0;
        m_paddr   = 32'h0800_0004;
        @(posedge clk); #1;
        m_penable = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("pre_rst_psel", s_psel, 3'b100);
        #2;
        rstn = 1'b0;
        #1;
        check_eq("async_rst_sel",    {s_psel, s_penable}, 6'b0);
        check_eq("async_rst_pready", m_pready, 1'b0);
        m_psel    = 1'b0;
        m_penable = 1'b0;
        model_to  = 0;
        @(posedge clk); @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        check_eq("post_rst_tocnt", to_cnt, 8'h00);
        do_xfer(32'h0000_0010, 1'b0, 2, 32'h0F0F_0F0F, 1'b0);
        idle_cycle();
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
